// File: rtl/lsu_mem_if.sv
// lsu_mem_if: RV32I load/store front end driving a fixed-latency data TCM.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into errors instead of forcing alignment.
module lsu_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;
    localparam logic [1:0] LAT     = 2'(RD_LATENCY);

    logic [1:0]            r_state;
    logic [1:0]            r_cnt;
    logic                  r_ready;
    logic                  r_store;
    logic                  r_err;
    logic [2:0]            r_f3;
    logic [1:0]            r_off;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic                  r_mem_we;
    logic [3:0]            r_mem_be;

    logic [1:0]            w_off;
    logic [1:0]            w_eff_off;
    logic                  w_is_h;
    logic                  w_is_w;
    logic                  w_f3_ok;
    logic                  w_mis;
    logic                  w_err;
    logic                  w_accept;
    logic                  w_busy;
    logic                  w_cnt_done;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_shift;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load;
    logic [1:0]            w_next;

    assign w_off    = req_addr_i[1:0];
    assign w_is_h   = req_funct3_i[1:0] == 2'b01;
    assign w_is_w   = req_funct3_i[1:0] == 2'b10;
    assign w_f3_ok  = req_we_i ? (!req_funct3_i[2] && req_funct3_i[1:0] != 2'b11)
                               : (req_funct3_i != 3'b011 && req_funct3_i[2:1] != 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_mis    = (w_is_h && w_off[0]) || (w_is_w && w_off != 2'b00);
`else
    assign w_mis    = 1'b0;
`endif
    // Natural alignment is forced here; with the trap enabled only aligned accesses reach memory anyway.
    assign w_eff_off = w_is_w ? 2'b00 : w_is_h ? {w_off[1], 1'b0} : w_off;
    assign w_err    = !w_f3_ok || w_mis;
    assign w_accept = req_valid_i && r_ready;
    assign w_be     = w_is_w ? 4'hF : w_is_h ? (w_off[1] ? 4'hC : 4'h3) : 4'b0001 << w_off;
    assign w_wdata  = w_is_w ? req_wdata_i : w_is_h ? {2{req_wdata_i[15:0]}} : {4{req_wdata_i[7:0]}};

    assign w_busy     = r_state == S_ISSUE || r_state == S_WAIT;
    assign w_cnt_done = r_cnt == LAT;
    assign w_shift    = mem_data_i >> {r_off, 3'b000};
    assign w_byte     = w_shift[7:0];
    assign w_half     = r_off[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    assign w_load     = r_f3[1] ? mem_data_i
                      : r_f3[0] ? {{16{!r_f3[2] && w_half[15]}}, w_half}
                      : {{24{!r_f3[2] && w_byte[7]}}, w_byte};

    always_comb begin
        w_next = S_IDLE;
        if (r_state == S_IDLE)
            w_next = w_accept ? (w_err ? S_RESP : S_ISSUE) : S_IDLE;
        else if (w_busy)
            w_next = (r_store || w_cnt_done) ? S_RESP : S_WAIT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_store    <= 1'b0;
            r_err      <= 1'b0;
            r_f3       <= '0;
            r_off      <= '0;
            r_rdata    <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_we   <= 1'b0;
            r_mem_be   <= '0;
        end else begin
            r_state  <= w_next;
            r_ready  <= w_next == S_IDLE;
            r_mem_we <= w_accept && req_we_i && !w_err;
            if (w_accept) begin
                r_store    <= req_we_i;
                r_f3       <= req_funct3_i;
                r_off      <= w_eff_off;
                r_err      <= w_err;
                r_cnt      <= '0;
                r_rdata    <= '0;
                r_mem_addr <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                r_mem_data <= w_wdata;
                r_mem_be   <= w_err ? 4'h0 : w_be;
            end else begin
                if (w_next == S_RESP || w_next == S_IDLE)
                    r_mem_be <= '0;
                if (w_busy && !r_store) begin
                    if (w_cnt_done)
                        r_rdata <= w_load;
                    else
                        r_cnt <= r_cnt + 2'd1;
                end
            end
        end
    end

    assign req_ready_o = r_ready;
    assign rsp_valid_o = r_state == S_RESP;
    assign rsp_rdata_o = rsp_valid_o ? r_rdata : '0;
    assign rsp_err_o   = rsp_valid_o && r_err;
    assign mem_addr_o  = r_mem_addr;
    assign mem_data_o  = r_mem_data;
    assign mem_we_o    = r_mem_we;
    assign mem_be_o    = r_mem_be;
endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: scoreboard bench for lsu_mem_if against a two-cycle-latency TCM model.
module tb_lsu_mem_if;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [2:0]  req_funct3_i = '0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_data_i;

    lsu_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    logic [31:0] tcm [0:1023];
    logic [31:0] rd_d1, rd_d2;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    initial for (int i = 0; i < 1024; i++) tcm[i] = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_d1 <= tcm[mem_addr_o[11:2]];
        rd_d2 <= rd_d1;
        if (mem_we_o)
            for (int b = 0; b < 4; b++)
                if (mem_be_o[b]) tcm[mem_addr_o[11:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
    end
    assign mem_data_i = rd_d2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct { logic [31:0] rd; logic err; int cyc; string tag; } exp_t;
    exp_t sb [$];

    always @(negedge clk) begin
        if (rsp_valid_o) begin
            if (sb.size() == 0) chk("spurious_rsp", 32'(rsp_valid_o), 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_rdata"}, rsp_rdata_o, e.rd);
                chk({e.tag, "_err"}, 32'(rsp_err_o), 32'(e.err));
                chk({e.tag, "_cyc"}, 32'(cyc), 32'(e.cyc));
            end
        end else begin
            if (rsp_rdata_o != 0 || rsp_err_o) chk("idle_rsp_zero", {rsp_rdata_o[30:0], rsp_err_o}, 32'd0);
        end
    end

    task automatic send(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] ebe, input logic [31:0] emd,
                        input logic [31:0] erd, input logic eerr);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
        if (!req_ready_o) chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = addr; req_wdata_i = wd;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        e.rd = erd; e.err = eerr; e.tag = tag;
        e.cyc = eerr ? cyc : (we ? cyc + 1 : cyc + 1 + LAT);
        sb.push_back(e);
        chk({tag, "_busy"}, 32'(req_ready_o), 32'd0);
        chk({tag, "_be"}, 32'(mem_be_o), 32'(eerr ? 4'h0 : ebe));
        chk({tag, "_we"}, 32'(mem_we_o), 32'(we && !eerr));
        if (!eerr) chk({tag, "_addr"}, mem_addr_o, {addr[31:2], 2'b00});
        if (we && !eerr) chk({tag, "_mdata"}, mem_data_o, emd);
        n = 0;
        while (sb.size() != 0 && n < 20) begin @(posedge clk); n++; end
        if (sb.size() != 0) begin
            chk({tag, "_no_rsp"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_rsp", 32'(rsp_valid_o), 32'd0);
        chk("rst_be", 32'(mem_be_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready_rise", 32'(req_ready_o), 32'd1);

        send("sw104", 1, 3'b010, 32'h104, 32'hA0B0C0D0, 4'hF, 32'hA0B0C0D0, 32'h0, 0);
        send("sb107", 1, 3'b000, 32'h107, 32'h00000055, 4'h8, 32'h55555555, 32'h0, 0);
        send("lw104", 0, 3'b010, 32'h104, 32'h0, 4'hF, 32'h0, 32'h55B0C0D0, 0);
        send("sh106", 1, 3'b001, 32'h106, 32'h1234ABCD, 4'hC, 32'hABCDABCD, 32'h0, 0);
        send("lhu106", 0, 3'b101, 32'h106, 32'h0, 4'hC, 32'h0, 32'h0000ABCD, 0);
        send("sw200", 1, 3'b010, 32'h200, 32'h80FF7F01, 4'hF, 32'h80FF7F01, 32'h0, 0);
        send("lb203", 0, 3'b000, 32'h203, 32'h0, 4'h8, 32'h0, 32'hFFFFFF80, 0);
        send("lbu203", 0, 3'b100, 32'h203, 32'h0, 4'h8, 32'h0, 32'h00000080, 0);
        send("lb200", 0, 3'b000, 32'h200, 32'h0, 4'h1, 32'h0, 32'h00000001, 0);
        send("lh202", 0, 3'b001, 32'h202, 32'h0, 4'hC, 32'h0, 32'hFFFF80FF, 0);
        send("lhu200", 0, 3'b101, 32'h200, 32'h0, 4'h3, 32'h0, 32'h00007F01, 0);
        send("ld_f011", 0, 3'b011, 32'h200, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        send("ld_f110", 0, 3'b110, 32'h200, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        send("st_f100", 1, 3'b100, 32'h200, 32'hDEADBEEF, 4'h0, 32'h0, 32'h0, 1);
        send("sw100", 1, 3'b010, 32'h100, 32'h00008001, 4'hF, 32'h00008001, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        send("lh101", 0, 3'b001, 32'h101, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        send("lw202", 0, 3'b010, 32'h202, 32'h0, 4'h0, 32'h0, 32'h0, 1);
`else
        send("lh101", 0, 3'b001, 32'h101, 32'h0, 4'h3, 32'h0, 32'hFFFF8001, 0);
        send("lw202", 0, 3'b010, 32'h202, 32'h0, 4'hF, 32'h0, 32'h80FF7F01, 0);
`endif
        // Abort a load mid-wait: nothing is pushed, so any response is flagged by the monitor.
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h200;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_be", 32'(mem_be_o), 32'd0);
        chk("abort_we", 32'(mem_we_o), 32'd0);
        chk("abort_ready_in_rst", 32'(req_ready_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready_rise", 32'(req_ready_o), 32'd1);
        repeat (6) @(posedge clk);
        send("sw300", 1, 3'b010, 32'h300, 32'h13572468, 4'hF, 32'h13572468, 32'h0, 0);
        send("lw300", 0, 3'b010, 32'h300, 32'h0, 4'hF, 32'h0, 32'h13572468, 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
